if_id_pipe_reg: RTL and testbench

- Next-generation IF/ID pipeline register, parametrised in PC/instruction width and NOP encoding.
- Adds a valid/ready handshake in both directions, a synchronous flush for branch redirect, and a saturating back-pressure counter.
- Sits between the fetch unit (upstream) and the decode stage (downstream).
- An optional 2-entry skid mode gives a fully registered upstream ready.

---
 rtl/if_id_pipe_reg.sv | 126 ++++++++++++
 tb/tb_if_id_pipe_reg.sv | 235 +++++++++++++++++++++++
 2 files changed

// File: rtl/if_id_pipe_reg.sv
// IF/ID pipeline register with valid/ready handshake on both sides, synchronous
// flush for branch redirect and a saturating back-pressure (stall) counter.
//
// Build option: define IF_ID_SKID_EN to add a second (skid) entry so that
// if_ready comes straight from a flop instead of from id_ready. The port list
// is the same in both builds.
module if_id_pipe_reg #(
    parameter int unsigned     XLEN      = 32,
    parameter int unsigned     ILEN      = 32,
    parameter logic [ILEN-1:0] NOP_INSTR = ILEN'(32'h00000013),
    parameter int unsigned     CNT_W     = 16
) (
    input  logic             clk,
    input  logic             rst,

    // Upstream (fetch) side
    input  logic             if_valid,
    output logic             if_ready,
    input  logic [XLEN-1:0]  if_pc,
    input  logic [ILEN-1:0]  if_instruction,

    // Downstream (decode) side
    output logic             id_valid,
    input  logic             id_ready,
    output logic [XLEN-1:0]  id_pc,
    output logic [ILEN-1:0]  id_instruction,

    // Control and status
    input  logic             flush,
    input  logic             stall_cnt_clr,
    output logic [CNT_W-1:0] stall_cnt
);

    localparam logic [CNT_W-1:0] CntMax = '1;

`ifdef IF_ID_SKID_EN

    logic            skid_valid;
    logic [XLEN-1:0] skid_pc;
    logic [ILEN-1:0] skid_instr;
    logic            if_ready_q;

    // Upstream ready is registered; it is low exactly while the skid entry holds a beat.
    assign if_ready = if_ready_q;

    // Main and skid entries: the skid entry always holds the younger beat and
    // drains into main before any new upstream beat is taken.
    always_ff @(posedge clk) begin
        if (rst) begin
            id_valid       <= 1'b0;
            id_pc          <= '0;
            id_instruction <= NOP_INSTR;
            skid_valid     <= 1'b0;
            skid_pc        <= '0;
            skid_instr     <= NOP_INSTR;
            if_ready_q     <= 1'b1;
        end else if (flush) begin
            id_valid       <= 1'b0;
            id_instruction <= NOP_INSTR;
            skid_valid     <= 1'b0;
            if_ready_q     <= 1'b1;
        end else if (skid_valid) begin
            // if_ready is low here, so no upstream beat can arrive this cycle
            if (id_ready) begin
                id_valid       <= 1'b1;
                id_pc          <= skid_pc;
                id_instruction <= skid_instr;
                skid_valid     <= 1'b0;
                if_ready_q     <= 1'b1;
            end
        end else if (!id_valid || id_ready) begin
            id_valid <= if_valid;
            if (if_valid) begin
                id_pc          <= if_pc;
                id_instruction <= if_instruction;
            end else begin
                id_instruction <= NOP_INSTR;
            end
        end else if (if_valid) begin
            // Main is stalled: park the arriving beat in the skid entry
            skid_valid <= 1'b1;
            skid_pc    <= if_pc;
            skid_instr <= if_instruction;
            if_ready_q <= 1'b0;
        end
    end

`else

    // Accept whenever the single entry is empty or is being drained this cycle.
    assign if_ready = !id_valid || id_ready;

    // Single-entry register; a simultaneous drain and fill replaces the beat with no bubble.
    always_ff @(posedge clk) begin
        if (rst) begin
            id_valid       <= 1'b0;
            id_pc          <= '0;
            id_instruction <= NOP_INSTR;
        end else if (flush) begin
            id_valid       <= 1'b0;
            id_instruction <= NOP_INSTR;
        end else if (if_ready) begin
            id_valid <= if_valid;
            if (if_valid) begin
                id_pc          <= if_pc;
                id_instruction <= if_instruction;
            end else begin
                id_instruction <= NOP_INSTR;
            end
        end
    end

`endif

    // Saturating count of cycles where decode back-pressures a valid beat; clear wins.
    always_ff @(posedge clk) begin
        if (rst) begin
            stall_cnt <= '0;
        end else if (stall_cnt_clr) begin
            stall_cnt <= '0;
        end else if (id_valid && !id_ready && (stall_cnt != CntMax)) begin
            stall_cnt <= stall_cnt + CNT_W'(1);
        end
    end

endmodule

// File: tb/tb_if_id_pipe_reg.sv
// Randomised scoreboard bench for if_id_pipe_reg. Works for both builds
// (IF_ID_SKID_EN defined or not); the stall counter is narrowed to 4 bits so
// saturation is reachable.
module tb_if_id_pipe_reg;

    localparam int unsigned XLEN  = 32;
    localparam int unsigned ILEN  = 32;
    localparam int unsigned CNT_W = 4;
    localparam logic [ILEN-1:0] NOP = 32'h00000013;
    localparam int unsigned CMAX = (1 << CNT_W) - 1;
`ifdef IF_ID_SKID_EN
    localparam int unsigned CAP = 2;
`else
    localparam int unsigned CAP = 1;
`endif

    typedef struct {
        logic [XLEN-1:0] pc;
        logic [ILEN-1:0] instr;
    } beat_t;

    logic             clk = 1'b0;
    logic             rst;
    logic             if_valid;
    logic             if_ready;
    logic [XLEN-1:0]  if_pc;
    logic [ILEN-1:0]  if_instruction;
    logic             id_valid;
    logic             id_ready;
    logic [XLEN-1:0]  id_pc;
    logic [ILEN-1:0]  id_instruction;
    logic             flush;
    logic             stall_cnt_clr;
    logic [CNT_W-1:0] stall_cnt;

    if_id_pipe_reg #(
        .XLEN      (XLEN),
        .ILEN      (ILEN),
        .NOP_INSTR (NOP),
        .CNT_W     (CNT_W)
    ) dut (
        .clk            (clk),
        .rst            (rst),
        .if_valid       (if_valid),
        .if_ready       (if_ready),
        .if_pc          (if_pc),
        .if_instruction (if_instruction),
        .id_valid       (id_valid),
        .id_ready       (id_ready),
        .id_pc          (id_pc),
        .id_instruction (id_instruction),
        .flush          (flush),
        .stall_cnt_clr  (stall_cnt_clr),
        .stall_cnt      (stall_cnt)
    );

    always #5 clk = ~clk;

    // Reference model: the stage is a FIFO of capacity CAP holding beats in arrival order.
    beat_t           mq[$];
    beat_t           sb[$];
    int unsigned     cnt_m   = 0;
    logic [XLEN-1:0] last_pc = '0;
    bit              mon_en  = 1'b0;

    int total = 0;
    int bad   = 0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic bit exp_if_ready();
        if (CAP == 2) return mq.size() < 2;
        return (mq.size() == 0) || id_ready;
    endfunction

    // Apply one clock edge to the model using the inputs that were present at the edge.
    task automatic model_edge();
        bit    acc;
        beat_t b;
        if (rst) begin
            mq.delete();
            sb.delete();
            cnt_m   = 0;
            last_pc = '0;
        end else begin
            if (stall_cnt_clr) cnt_m = 0;
            else if (mq.size() > 0 && !id_ready && cnt_m < CMAX) cnt_m++;
            if (flush) begin
                mq.delete();
                sb.delete();
            end else begin
                acc = if_valid && exp_if_ready();
                if (mq.size() > 0 && id_ready) void'(mq.pop_front());
                if (acc) begin
                    b.pc    = if_pc;
                    b.instr = if_instruction;
                    mq.push_back(b);
                    sb.push_back(b);
                end
            end
            if (mq.size() > 0) last_pc = mq[0].pc;
        end
    endtask

    task automatic cycle();
        @(posedge clk);
        #1;
        model_edge();
    endtask

    task automatic drive(input logic v, input logic [XLEN-1:0] pc, input logic [ILEN-1:0] ins,
                         input logic rdy, input logic fl, input logic clr);
        if_valid       = v;
        if_pc          = pc;
        if_instruction = ins;
        id_ready       = rdy;
        flush          = fl;
        stall_cnt_clr  = clr;
    endtask

    // Monitor: compares every cycle and pops the scoreboard on each downstream transfer.
    always @(negedge clk) begin
        beat_t b;
        if (mon_en) begin
            check("id_valid", {63'd0, id_valid}, {63'd0, mq.size() > 0});
            check("if_ready", {63'd0, if_ready}, {63'd0, exp_if_ready()});
            check("stall_cnt", 64'(stall_cnt), 64'(cnt_m));
            check("id_pc", 64'(id_pc), 64'(last_pc));
            if (!id_valid) check("nop_when_empty", 64'(id_instruction), 64'(NOP));
            if (id_valid && id_ready && !flush && !rst) begin
                if (sb.size() == 0) begin
                    total++;
                    bad++;
                    $display("FAIL sb_underflow: got transfer pc %0h expected no beat at %0t",
                             id_pc, $time);
                end else begin
                    b = sb.pop_front();
                    check("xfer_pc", 64'(id_pc), 64'(b.pc));
                    check("xfer_instr", 64'(id_instruction), 64'(b.instr));
                end
            end
        end
    end

    initial begin
        drive(1'b0, '0, '0, 1'b1, 1'b0, 1'b0);
        rst = 1'b1;
        cycle();
        mon_en = 1'b1;
        cycle();
        check("rst_instr", 64'(id_instruction), 64'(NOP));
        check("rst_if_ready", {63'd0, if_ready}, 64'd1);
        rst = 1'b0;

        // First beat: visible one cycle after transfer
        drive(1'b1, 32'h100, 32'h00500093, 1'b1, 1'b0, 1'b0);
        cycle();
        check("first_valid", {63'd0, id_valid}, 64'd1);
        check("first_pc", 64'(id_pc), 64'h100);
        check("first_instr", 64'(id_instruction), 64'h00500093);

        // Back-to-back stream, no bubbles
        for (int i = 0; i < 3; i++) begin
            drive(1'b1, 32'(i * 4), 32'h1000 + 32'(i), 1'b1, 1'b0, 1'b0);
            cycle();
            check("stream_pc", 64'(id_pc), 64'(i * 4));
        end
        drive(1'b0, '0, '0, 1'b1, 1'b0, 1'b1);
        cycle();

        // Hold a beat for 5 stalled cycles while a second beat is offered
        drive(1'b1, 32'h0, 32'h2000, 1'b0, 1'b0, 1'b0);
        cycle();
        drive(1'b1, 32'h4, 32'h2004, 1'b0, 1'b0, 1'b0);
        repeat (5) cycle();
        check("stall5_cnt", 64'(stall_cnt), 64'd5);
        check("stall5_pc", 64'(id_pc), 64'h0);
        drive(1'b0, '0, '0, 1'b1, 1'b0, 1'b0);
        repeat (3) cycle();

        // Flush with a full stage and an incoming beat
        drive(1'b1, 32'h40, 32'h3000, 1'b0, 1'b0, 1'b0);
        cycle();
        drive(1'b1, 32'h44, 32'h3004, 1'b0, 1'b1, 1'b0);
        cycle();
        check("flush_valid", {63'd0, id_valid}, 64'd0);
        check("flush_instr", 64'(id_instruction), 64'(NOP));

        // Saturation then clear against a simultaneous stall
        drive(1'b1, 32'h80, 32'h4000, 1'b0, 1'b0, 1'b1);
        cycle();
        drive(1'b0, '0, '0, 1'b0, 1'b0, 1'b0);
        repeat (20) cycle();
        check("sat_cnt", 64'(stall_cnt), 64'(CMAX));
        stall_cnt_clr = 1'b1;
        cycle();
        check("clr_beats_inc", 64'(stall_cnt), 64'd0);
        stall_cnt_clr = 1'b0;

        // Reset while stalled with both entries occupied (where present)
        drive(1'b1, 32'h84, 32'h4004, 1'b0, 1'b0, 1'b0);
        repeat (2) cycle();
        rst = 1'b1;
        cycle();
        rst = 1'b0;
        check("rst_mid_valid", {63'd0, id_valid}, 64'd0);
        check("rst_mid_pc", 64'(id_pc), 64'd0);
        check("rst_mid_cnt", 64'(stall_cnt), 64'd0);
        check("rst_mid_ready", {63'd0, if_ready}, 64'd1);

        // Randomised traffic
        for (int i = 0; i < 3000; i++) begin
            drive($urandom_range(0, 9) < 7, $urandom() & ~32'h3, $urandom(),
                  $urandom_range(0, 9) < ((i / 300) % 2 == 0 ? 6 : 2),
                  $urandom_range(0, 49) == 0, $urandom_range(0, 39) == 0);
            rst = ($urandom_range(0, 299) == 0);
            cycle();
        end
        drive(1'b0, '0, '0, 1'b1, 1'b0, 1'b0);
        rst = 1'b0;
        repeat (4) cycle();
        check("drained_sb", 64'(sb.size()), 64'd0);

        mon_en = 1'b0;
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
